// File: rtl/multi_gate_unit.sv
// Two-stage valid/ready gate unit: bitwise or reduce-over-A logic functions with an
// illegal-opcode flag and a wrapping count of completed output transfers.
module multi_gate_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             reduce,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    OpNotA = 3'd0,
    OpOr   = 3'd1,
    OpAnd  = 3'd2,
    OpNor  = 3'd3,
    OpXor  = 3'd4,
    OpXnor = 3'd5
  } op_e;

  // Stage 1: captured operands
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  op_e              s1_op_q;
  logic             s1_reduce_q;

  // Stage 2: computed result
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_err_q;

  logic [CNT_W-1:0] count_q;

  logic             out_fire;
  logic             s2_load;
  logic [WIDTH-1:0] calc_result;
  logic             calc_err;
  logic [WIDTH-1:0] bw_result;
  logic             red_bit;

  assign out_fire = s2_valid_q & out_ready;
  // S2 may refill in the same cycle its current item leaves
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;

  always_comb begin
    bw_result = '0;
    red_bit   = 1'b0;
    calc_err  = 1'b0;
    unique case (s1_op_q)
      OpNotA: begin bw_result = ~s1_a_q;             red_bit = ~&s1_a_q; end
      OpOr:   begin bw_result = s1_a_q | s1_b_q;     red_bit = |s1_a_q;  end
      OpAnd:  begin bw_result = s1_a_q & s1_b_q;     red_bit = &s1_a_q;  end
      OpNor:  begin bw_result = ~(s1_a_q | s1_b_q);  red_bit = ~|s1_a_q; end
      OpXor:  begin bw_result = s1_a_q ^ s1_b_q;     red_bit = ^s1_a_q;  end
      OpXnor: begin bw_result = ~(s1_a_q ^ s1_b_q);  red_bit = ~^s1_a_q; end
      default: calc_err = 1'b1;
    endcase
  end

  always_comb begin
    calc_result = '0;
    if (!calc_err) begin
      calc_result = s1_reduce_q ? {{(WIDTH-1){1'b0}}, red_bit} : bw_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OpNotA;
      s1_reduce_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q      <= a;
        s1_b_q      <= b;
        s1_op_q     <= op_e'(op);
        s1_reduce_q <= reduce;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_err_q    <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q  <= 1'b1;
      s2_result_q <= calc_result;
      s2_err_q    <= calc_err;
    end else if (out_fire) begin
      s2_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (out_fire) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_result_q;
  assign err       = s2_err_q;
  assign count     = count_q;

endmodule
